// File: rtl/fpu_issue_controller_pkg.sv
// Shared definitions for the fixed-point unit issue controller: op codes, FSM states, defaults.
package fpu_issue_controller_pkg;

   // Operation codes, identical to the `FPU_ADD / `FPU_SUB / `FPU_MUL / `FPU_SQRT values in Defines.vh
   localparam logic [1:0] FPU_ADD  = 2'b00;
   localparam logic [1:0] FPU_SUB  = 2'b01;
   localparam logic [1:0] FPU_MUL  = 2'b10;
   localparam logic [1:0] FPU_SQRT = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } issue_state_t;

   localparam int DEFAULT_TIMEOUT = 64;
   localparam int FBITS           = 10;

   // Multi-cycle ops can still show the previous operation's ready in their first busy cycle.
   function automatic logic is_multicycle(input logic [1:0] op);
      return (op == FPU_MUL) || (op == FPU_SQRT);
   endfunction

endpackage

// File: rtl/fpu_issue_watchdog.sv
// Busy-cycle counter for the issue controller; flags the last permitted busy cycle.
module fpu_issue_watchdog
   import fpu_issue_controller_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic busy,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count_r;

   // Count busy cycles, restarting on each accepted request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (busy && (count_r != CNT_W'(TIMEOUT))) begin
         count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = busy && (count_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_issue_controller.sv
// Issues one request at a time to the fixed-point unit and hands the result to writeback.
// Optional busy timeout with error completion is enabled by defining FPU_ISSUE_TIMEOUT_EN.
module fpu_issue_controller
   import fpu_issue_controller_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int RD_W  = 5
`ifdef FPU_ISSUE_TIMEOUT_EN
   , parameter int TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [RD_W-1:0]  req_rd,
   output logic [WIDTH-1:0] fpu_operand_1,
   output logic [WIDTH-1:0] fpu_operand_2,
   output logic [1:0]       fpu_operation,
   output logic             fpu_start,
   input  logic [WIDTH-1:0] fpu_result,
   input  logic             fpu_ready,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [WIDTH-1:0] wb_result,
   output logic [RD_W-1:0]  wb_rd,
   output logic             wb_error
);

   issue_state_t    state_r;
   issue_state_t    state_s;
   logic            first_r;
   logic [RD_W-1:0] rd_r;
   logic            accept_s;
   logic            qualified_s;
   logic            expired_s;
   logic            finish_s;

   assign req_ready   = (state_r == IDLE);
   assign accept_s    = req_valid && (state_r == IDLE);
   assign qualified_s = (state_r == BUSY) && fpu_ready &&
                        !(first_r && is_multicycle(fpu_operation));
   assign finish_s    = qualified_s || expired_s;

`ifdef FPU_ISSUE_TIMEOUT_EN
   logic error_r;

   fpu_issue_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (accept_s),
      .busy    (state_r == BUSY),
      .expired (expired_s)
   );

   // Error flag: set by an expiry without a qualified ready, cleared by a real result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error_r <= 1'b0;
      end else if (finish_s) begin
         error_r <= !qualified_s;
      end else begin
         error_r <= error_r;
      end
   end

   assign wb_error = error_r;
`else
   assign expired_s = 1'b0;
   assign wb_error  = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    if (accept_s) state_s = BUSY; else state_s = IDLE;
         BUSY:    if (finish_s) state_s = DONE; else state_s = BUSY;
         DONE:    if (wb_ready) state_s = IDLE; else state_s = DONE;
         default: state_s = IDLE;
      endcase
   end

   // Unit-side drive and writeback capture; the unit returns to a neutral ADD of zeros on completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fpu_operand_1 <= '0;
         fpu_operand_2 <= '0;
         fpu_operation <= FPU_ADD;
         fpu_start     <= 1'b0;
         first_r       <= 1'b0;
         rd_r          <= '0;
         wb_valid      <= 1'b0;
         wb_result     <= '0;
         wb_rd         <= '0;
      end else begin
         fpu_start <= 1'b0;
         if (accept_s) begin
            fpu_operand_1 <= req_a;
            fpu_operand_2 <= req_b;
            fpu_operation <= req_op;
            fpu_start     <= (req_op == FPU_SQRT);
            first_r       <= 1'b1;
            rd_r          <= req_rd;
         end else if (state_r == BUSY) begin
            first_r <= 1'b0;
            if (finish_s) begin
               fpu_operand_1 <= '0;
               fpu_operand_2 <= '0;
               fpu_operation <= FPU_ADD;
               wb_valid      <= 1'b1;
               wb_rd         <= rd_r;
               wb_result     <= qualified_s ? fpu_result : {WIDTH{1'b0}};
            end else begin
               wb_valid <= wb_valid;
            end
         end else if ((state_r == DONE) && wb_ready) begin
            wb_valid <= 1'b0;
         end else begin
            wb_valid <= wb_valid;
         end
      end
   end

endmodule

// File: tb/tb_fpu_issue_controller.sv
// Directed bench for fpu_issue_controller; a behavioural Q22.10 unit model supplies results.
// Timeout vectors run only when FPU_ISSUE_TIMEOUT_EN is defined (built with TIMEOUT=8).
module tb_fpu_issue_controller;
   import fpu_issue_controller_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [4:0]  req_rd;
   logic [31:0] fpu_operand_1;
   logic [31:0] fpu_operand_2;
   logic [1:0]  fpu_operation;
   logic        fpu_start;
   logic [31:0] fpu_result;
   logic        fpu_ready;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_result;
   logic [4:0]  wb_rd;
   logic        wb_error;

   int n_cmp = 0;
   int n_mis = 0;
   logic signed [63:0] prod_s;

   always #5 clk = ~clk;

   fpu_issue_controller #(
      .WIDTH (32),
      .RD_W  (5)
`ifdef FPU_ISSUE_TIMEOUT_EN
      , .TIMEOUT (8)
`endif
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_rd        (req_rd),
      .fpu_operand_1 (fpu_operand_1),
      .fpu_operand_2 (fpu_operand_2),
      .fpu_operation (fpu_operation),
      .fpu_start     (fpu_start),
      .fpu_result    (fpu_result),
      .fpu_ready     (fpu_ready),
      .wb_valid      (wb_valid),
      .wb_ready      (wb_ready),
      .wb_result     (wb_result),
      .wb_rd         (wb_rd),
      .wb_error      (wb_error)
   );

   // Behavioural unit: arithmetic in Q22.10, sqrt from a one-entry table.
   always_comb begin
      prod_s = longint'($signed(fpu_operand_1)) * longint'($signed(fpu_operand_2));
      case (fpu_operation)
         FPU_ADD: fpu_result = fpu_operand_1 + fpu_operand_2;
         FPU_SUB: fpu_result = fpu_operand_1 - fpu_operand_2;
         FPU_MUL: fpu_result = prod_s[41:10];
         default: fpu_result = (fpu_operand_1 == 32'h0000_1000) ? 32'h0000_0800 : 32'h0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_rd    = rd;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_op    = FPU_ADD;
      req_a     = 32'h0;
      req_b     = 32'h0;
      req_rd    = 5'd0;
      fpu_ready = 1'b0;
      wb_ready  = 1'b1;
      tick();
      check("rst_req_ready", {31'h0, req_ready}, 32'h1);
      check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
      check("rst_operation", {30'h0, fpu_operation}, {30'h0, FPU_ADD});
      check("rst_operand_1", fpu_operand_1, 32'h0);
      check("rst_wb_error", {31'h0, wb_error}, 32'h0);
      reset = 1'b0;
      tick();

      // ADD 1.5 + 2.25: combinational unit, ready honoured in the first busy cycle
      fpu_ready = 1'b1;
      present(FPU_ADD, 32'h600, 32'h900, 5'd3);
      tick();
      req_valid = 1'b0;
      check("add_busy_ready", {31'h0, req_ready}, 32'h0);
      check("add_busy_wbv", {31'h0, wb_valid}, 32'h0);
      check("add_operand_1", fpu_operand_1, 32'h600);
      check("add_operand_2", fpu_operand_2, 32'h900);
      tick();
      check("add_wbv", {31'h0, wb_valid}, 32'h1);
      check("add_result", wb_result, 32'hF00);
      check("add_rd", {27'h0, wb_rd}, 32'd3);
      check("add_error", {31'h0, wb_error}, 32'h0);
      check("add_neutral_op1", fpu_operand_1, 32'h0);
      tick();
      check("add_release_wbv", {31'h0, wb_valid}, 32'h0);
      check("add_release_ready", {31'h0, req_ready}, 32'h1);

      // SUB with writeback stalled for 5 cycles while another request waits upstream
      wb_ready = 1'b0;
      present(FPU_SUB, 32'h400, 32'h800, 5'd7);
      tick();
      req_valid = 1'b0;
      tick();
      present(FPU_MUL, 32'h123, 32'h456, 5'd9);
      for (int i = 0; i < 5; i++) begin
         check("sub_hold_wbv", {31'h0, wb_valid}, 32'h1);
         check("sub_hold_result", wb_result, 32'hFFFF_FC00);
         check("sub_hold_rd", {27'h0, wb_rd}, 32'd7);
         check("sub_hold_ready", {31'h0, req_ready}, 32'h0);
         check("sub_hold_op", {30'h0, fpu_operation}, {30'h0, FPU_ADD});
         tick();
      end
      req_valid = 1'b0;
      wb_ready  = 1'b1;
      tick();
      check("sub_release_wbv", {31'h0, wb_valid}, 32'h0);
      check("sub_release_ready", {31'h0, req_ready}, 32'h1);

      // Back-to-back MUL with a stale ready in each first busy cycle
      present(FPU_MUL, 32'h600, 32'h600, 5'd4);
      tick();
      req_valid = 1'b0;
      check("mul1_op", {30'h0, fpu_operation}, {30'h0, FPU_MUL});
      tick();
      check("mul1_stale_masked", {31'h0, wb_valid}, 32'h0);
      fpu_ready = 1'b0;
      tick();
      check("mul1_wait", {31'h0, wb_valid}, 32'h0);
      fpu_ready = 1'b1;
      tick();
      check("mul1_wbv", {31'h0, wb_valid}, 32'h1);
      check("mul1_result", wb_result, 32'h900);
      check("mul1_gap_done", {30'h0, fpu_operation}, {30'h0, FPU_ADD});
      present(FPU_MUL, 32'h800, 32'hC00, 5'd5);
      tick();
      check("mul_gap_idle", {30'h0, fpu_operation}, {30'h0, FPU_ADD});
      check("mul_gap_wbv", {31'h0, wb_valid}, 32'h0);
      tick();
      req_valid = 1'b0;
      check("mul2_op", {30'h0, fpu_operation}, {30'h0, FPU_MUL});
      check("mul2_operand_2", fpu_operand_2, 32'hC00);
      tick();
      check("mul2_stale_masked", {31'h0, wb_valid}, 32'h0);
      tick();
      check("mul2_wbv", {31'h0, wb_valid}, 32'h1);
      check("mul2_result", wb_result, 32'h1800);
      check("mul2_rd", {27'h0, wb_rd}, 32'd5);
      tick();

      // SQRT of 4.0: single start pulse, stale ready ignored
      present(FPU_SQRT, 32'h1000, 32'hDEAD, 5'd11);
      tick();
      req_valid = 1'b0;
      check("sqrt_start", {31'h0, fpu_start}, 32'h1);
      check("sqrt_op", {30'h0, fpu_operation}, {30'h0, FPU_SQRT});
      tick();
      check("sqrt_start_once", {31'h0, fpu_start}, 32'h0);
      check("sqrt_stale_masked", {31'h0, wb_valid}, 32'h0);
      fpu_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("sqrt_no_restart", {31'h0, fpu_start}, 32'h0);
      end
      fpu_ready = 1'b1;
      tick();
      check("sqrt_wbv", {31'h0, wb_valid}, 32'h1);
      check("sqrt_result", wb_result, 32'h800);
      check("sqrt_rd", {27'h0, wb_rd}, 32'd11);
      tick();

      // Reset in the middle of a MUL: result discarded
      fpu_ready = 1'b0;
      present(FPU_MUL, 32'h600, 32'h600, 5'd2);
      tick();
      req_valid = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      check("midrst_ready", {31'h0, req_ready}, 32'h1);
      check("midrst_wbv", {31'h0, wb_valid}, 32'h0);
      check("midrst_op", {30'h0, fpu_operation}, {30'h0, FPU_ADD});
      check("midrst_operand_1", fpu_operand_1, 32'h0);
      tick();
      reset     = 1'b0;
      fpu_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("midrst_no_wb", {31'h0, wb_valid}, 32'h0);
      end

`ifdef FPU_ISSUE_TIMEOUT_EN
      // Ready never arrives: error completion after 8 busy cycles
      fpu_ready = 1'b0;
      present(FPU_MUL, 32'h600, 32'h600, 5'd6);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         check("to_wait", {31'h0, wb_valid}, 32'h0);
      end
      tick();
      check("to_wbv", {31'h0, wb_valid}, 32'h1);
      check("to_error", {31'h0, wb_error}, 32'h1);
      check("to_result", wb_result, 32'h0);
      check("to_neutral", {30'h0, fpu_operation}, {30'h0, FPU_ADD});
      tick();

      // Ready on the 8th busy cycle: the real result wins
      present(FPU_MUL, 32'h600, 32'h600, 5'd6);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         check("race_wait", {31'h0, wb_valid}, 32'h0);
      end
      fpu_ready = 1'b1;
      tick();
      check("race_wbv", {31'h0, wb_valid}, 32'h1);
      check("race_error", {31'h0, wb_error}, 32'h0);
      check("race_result", wb_result, 32'h900);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
